ly_oneshot_stop_ctrl: RTL and testbench

Sequencer for the `trig_stop` line shared by all layer one-shot arrays in the chamber. It decides when the one-shot banks are frozen and arbitrates among three freeze sources: the post-trigger dead-time, test-pulse blanking and an external inhibit level. It also applies a startup blanking window after reset and keeps saturating statistics for slow control. It sits between the trigger/pattern logic and the six layer one-shot instances, and drives their common `trig_stop`.

---
 rtl/ly_oneshot_stop_ctrl.sv | 127 ++++++++++++
 tb/tb_ly_oneshot_stop_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ly_oneshot_stop_ctrl.sv
// Freeze sequencer for the shared one-shot trig_stop: startup blanking, trigger dead-time, TP blanking, external inhibit.
// Latency: trig_stop and tp_ack are registered, so they respond one edge after the sampled input; there is no backpressure, and unaccepted triggers are counted.
module ly_oneshot_stop_ctrl #(
  parameter int unsigned STARTUP_LEN = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig_found,
  input  logic [3:0]       dead_time,
  input  logic             tp_req,
  input  logic [3:0]       tp_len,
  input  logic             ext_inhibit,
  input  logic             cnt_clr,
  output logic             trig_stop,
  output logic             tp_ack,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stop_cnt,
  output logic [7:0]       lost_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTUP  = 3'd1,
    S_HOLD     = 3'd2,
    S_TP_BLANK = 3'd3,
    S_INHIBIT  = 3'd4
  } state_t;

  localparam logic [7:0] STARTUP_INIT = 8'(STARTUP_LEN - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] cnt;
  logic [7:0] nxt_cnt;
  logic       nxt_ack;
  logic       trig_req;
  logic       trig_lost;

  assign trig_req = trig_found & en;
  assign state    = cur_state;

  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cnt;
    nxt_ack   = 1'b0;
    trig_lost = 1'b0;
    case (cur_state)
      S_STARTUP: begin
        // Triggers during startup blanking are neither accepted nor counted as lost.
        if (cnt == 8'd0) begin
          nxt_state = ext_inhibit ? S_INHIBIT : S_IDLE;
        end else begin
          nxt_cnt = cnt - 8'd1;
        end
      end
      S_IDLE: begin
        if (ext_inhibit) begin
          nxt_state = S_INHIBIT;
          trig_lost = trig_req;
        end else if (tp_req) begin
          nxt_state = S_TP_BLANK;
          nxt_cnt   = {4'd0, tp_len};
          nxt_ack   = 1'b1;
          trig_lost = trig_req;
        end else if (trig_req) begin
          nxt_state = S_HOLD;
          nxt_cnt   = {4'd0, dead_time};
        end
      end
      S_HOLD, S_TP_BLANK: begin
        // Timed windows always exit via IDLE so the one-shots see a release cycle.
        trig_lost = trig_req;
        if (ext_inhibit) begin
          nxt_state = S_INHIBIT;
        end else if (cnt == 8'd0) begin
          nxt_state = S_IDLE;
        end else begin
          nxt_cnt = cnt - 8'd1;
        end
      end
      S_INHIBIT: begin
        trig_lost = trig_req;
        if (!ext_inhibit) begin
          nxt_state = S_IDLE;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_STARTUP;
      cnt       <= STARTUP_INIT;
      trig_stop <= 1'b1;
      tp_ack    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= nxt_cnt;
      trig_stop <= (nxt_state != S_IDLE);
      tp_ack    <= nxt_ack;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_cnt <= '0;
      lost_cnt <= 8'd0;
    end else if (cnt_clr) begin
      stop_cnt <= '0;
      lost_cnt <= 8'd0;
    end else begin
      if (trig_stop && (stop_cnt != {CNT_W{1'b1}})) begin
        stop_cnt <= stop_cnt + CNT_W'(1);
      end
      if (trig_lost && (lost_cnt != 8'hFF)) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ly_oneshot_stop_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expected events, a negedge monitor pops them as trig_stop edges, tp_ack pulses and probes occur.
module tb_ly_oneshot_stop_ctrl;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_ACK   = 2;
  localparam int K_PROBE = 3;

  typedef struct {
    int kind;
    int id;
    int st;
    int len;
    int ts;
    int stp;
    int lst;
  } exp_t;

  exp_t q[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        trig_found;
  logic [3:0]  dead_time;
  logic        tp_req;
  logic [3:0]  tp_len;
  logic        ext_inhibit;
  logic        cnt_clr;
  logic        trig_stop;
  logic        tp_ack;
  logic [2:0]  state;
  logic [15:0] stop_cnt;
  logic [7:0]  lost_cnt;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   run      = 0;
  int   cur_id   = 0;
  logic prev_ts  = 1'b1;
  logic probe    = 1'b0;

  always #5 clk = ~clk;

  ly_oneshot_stop_ctrl #(.STARTUP_LEN(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .trig_found (trig_found),
    .dead_time  (dead_time),
    .tp_req     (tp_req),
    .tp_len     (tp_len),
    .ext_inhibit(ext_inhibit),
    .cnt_clr    (cnt_clr),
    .trig_stop  (trig_stop),
    .tp_ack     (tp_ack),
    .state      (state),
    .stop_cnt   (stop_cnt),
    .lost_cnt   (lost_cnt)
  );

  task automatic push(input int kind, input int st, input int len, input int ts,
                      input int stp, input int lst);
    exp_t e;
    e.kind = kind; e.id = cur_id; e.st = st; e.len = len;
    e.ts = ts; e.stp = stp; e.lst = lst;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_probe(input int st, input int ts, input int stp, input int lst);
    push(K_PROBE, st, 0, ts, stp, lst);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic check_evt(input int kind, input int len);
    exp_t e;
    logic ok;
    n_checks++;
    if (q.size() == 0) begin
      n_fails++;
      $display("FAIL test%0d unexpected event: got kind=%0d state=%0d len=%0d, required no event",
               cur_id, kind, state, len);
    end else begin
      e  = q.pop_front();
      ok = (kind == e.kind) && (int'(state) == e.st);
      if (e.kind == K_FALL)  ok = ok && (len == e.len);
      if (e.kind == K_ACK)   ok = ok && (int'(trig_stop) == e.ts);
      if (e.kind == K_PROBE) ok = ok && (int'(trig_stop) == e.ts) && (int'(stop_cnt) == e.stp)
                                   && (int'(lost_cnt) == e.lst) && (tp_ack == 1'b0);
      if (!ok) begin
        n_fails++;
        $display("FAIL test%0d event: got kind=%0d st=%0d len=%0d ts=%0d stop=%0d lost=%0d ack=%0d, required kind=%0d st=%0d len=%0d ts=%0d stop=%0d lost=%0d",
                 e.id, kind, state, len, trig_stop, stop_cnt, lost_cnt, tp_ack,
                 e.kind, e.st, e.len, e.ts, e.stp, e.lst);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      run     = 0;
      prev_ts = trig_stop;
    end else begin
      if (trig_stop) run++;
      if (trig_stop && !prev_ts) check_evt(K_RISE, run);
      if (!trig_stop && prev_ts) check_evt(K_FALL, run);
      if (tp_ack) check_evt(K_ACK, run);
      if (!trig_stop) run = 0;
      prev_ts = trig_stop;
    end
    if (probe) check_evt(K_PROBE, run);
  end

  initial begin
    rst = 1'b1; en = 1'b0; trig_found = 1'b0; dead_time = 4'd0; tp_req = 1'b0;
    tp_len = 4'd0; ext_inhibit = 1'b0; cnt_clr = 1'b0;

    // 1: reset values and startup blanking
    step(); step();
    cur_id = 1;
    do_probe(1, 1, 0, 0);
    push(K_FALL, 0, 16, 0, 0, 0);
    rst = 1'b0;
    repeat (20) step();
    do_probe(0, 0, 16, 0);

    // 2: en gating, dead-time window, no retrigger
    cur_id = 2;
    trig_found = 1'b1; step(); trig_found = 1'b0; en = 1'b1; step();
    dead_time = 4'd3;
    push(K_RISE, 2, 0, 0, 0, 0);
    push(K_FALL, 0, 4, 0, 0, 0);
    trig_found = 1'b1; step(); trig_found = 1'b0; step();
    trig_found = 1'b1; step(); trig_found = 1'b0;
    repeat (6) step();
    do_probe(0, 0, 20, 1);

    // 3: tp_req beats trig_found in IDLE
    cur_id = 3;
    tp_len = 4'd5;
    push(K_RISE, 3, 0, 0, 0, 0);
    push(K_ACK, 3, 0, 1, 0, 0);
    push(K_FALL, 0, 6, 0, 0, 0);
    tp_req = 1'b1; trig_found = 1'b1; step();
    tp_req = 1'b0; trig_found = 1'b0;
    repeat (10) step();
    do_probe(0, 0, 26, 2);

    // 4: inhibit during HOLD, trigger lost while inhibited
    cur_id = 4;
    dead_time = 4'd7;
    push(K_RISE, 2, 0, 0, 0, 0);
    trig_found = 1'b1; step(); trig_found = 1'b0; step();
    ext_inhibit = 1'b1; step();
    do_probe(4, 1, 28, 2);
    trig_found = 1'b1; step(); trig_found = 1'b0;
    repeat (7) step();
    push(K_FALL, 0, 12, 0, 0, 0);
    ext_inhibit = 1'b0;
    repeat (4) step();
    do_probe(0, 0, 38, 3);

    // 5: tp_req during HOLD waits for IDLE; mid-window dead_time change ignored
    cur_id = 5;
    dead_time = 4'd2; tp_len = 4'd1;
    push(K_RISE, 2, 0, 0, 0, 0);
    push(K_FALL, 0, 3, 0, 0, 0);
    push(K_RISE, 3, 0, 0, 0, 0);
    push(K_ACK, 3, 0, 1, 0, 0);
    push(K_FALL, 0, 2, 0, 0, 0);
    trig_found = 1'b1; step();
    trig_found = 1'b0; tp_req = 1'b1; dead_time = 4'd9;
    repeat (4) step();
    tp_req = 1'b0;
    repeat (6) step();
    do_probe(0, 0, 43, 3);

    // 6: saturation under long inhibit, 1-high/1-low retrigger, clear beats increment
    cur_id = 6;
    dead_time = 4'd0;
    push(K_RISE, 4, 0, 0, 0, 0);
    ext_inhibit = 1'b1; trig_found = 1'b1; step();
    repeat (66000) step();
    do_probe(4, 1, 65535, 255);
    push(K_FALL, 0, 66002, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      push(K_RISE, 2, 0, 0, 0, 0);
      push(K_FALL, 0, 1, 0, 0, 0);
    end
    ext_inhibit = 1'b0;
    repeat (20) step();
    trig_found = 1'b0;
    repeat (3) step();
    do_probe(0, 0, 65535, 255);
    push(K_RISE, 2, 0, 0, 0, 0);
    push(K_FALL, 0, 1, 0, 0, 0);
    trig_found = 1'b1; step();
    cnt_clr = 1'b1; step();
    cnt_clr = 1'b0; trig_found = 1'b0;
    do_probe(0, 0, 0, 0);

    // 7: async reset mid-HOLD, startup ignores trig/tp_req
    cur_id = 7;
    dead_time = 4'd7;
    push(K_RISE, 2, 0, 0, 0, 0);
    trig_found = 1'b1; step(); trig_found = 1'b0; step();
    rst = 1'b1;
    do_probe(1, 1, 0, 0);
    push(K_FALL, 0, 16, 0, 0, 0);
    rst = 1'b0;
    repeat (3) step();
    trig_found = 1'b1; tp_req = 1'b1; step();
    trig_found = 1'b0; tp_req = 1'b0;
    repeat (20) step();
    do_probe(0, 0, 16, 0);

    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fails++;
      $display("FAIL test%0d missing event: got none, required kind=%0d st=%0d len=%0d",
               e.id, e.kind, e.st, e.len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
